// File: rtl/cpu_pkg.sv
// Shared definitions for the 12-bit microprocessor.
//   - Opcode constants (IR[11:8]).
//   - Accumulator source and ALU operation encodings.
//   - Fetch/decode FSM state encoding.
//   - Strobe bundle handed from the decoder to the execute unit.
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_ST  = 4'hB;
    localparam logic [3:0] OP_NOP = 4'hC;
    localparam logic [3:0] OP_LDI = 4'hD;
    localparam logic [3:0] OP_RST = 4'hE;

    typedef enum logic [1:0] {
        ASrcAlu = 2'd0,
        ASrcR   = 2'd1,
        ASrcImm = 2'd2
    } a_src_e;

    typedef enum logic [1:0] {
        AluNone = 2'd0,
        AluAdd  = 2'd1,
        AluInc  = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2
    } state_e;

    typedef struct packed {
        logic    a_we;
        a_src_e  a_src;
        alu_op_e alu_op;
        logic    r_we;
        logic    soft_rst;
        logic    illegal;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '{
        a_we:     1'b0,
        a_src:    ASrcAlu,
        alu_op:   AluNone,
        r_we:     1'b0,
        soft_rst: 1'b0,
        illegal:  1'b0
    };

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder.
//   opcode  : IR[11:8]
//   strobes : execute-unit control strobes for that opcode
// Undefined opcodes raise only 'illegal' and otherwise behave as nop.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output strobes_t   strobes
);

    always_comb begin
        strobes = STROBES_IDLE;
        case (opcode)
            OP_ADD: begin
                strobes.a_we   = 1'b1;
                strobes.a_src  = ASrcAlu;
                strobes.alu_op = AluAdd;
            end
            OP_INC: begin
                strobes.a_we   = 1'b1;
                strobes.a_src  = ASrcAlu;
                strobes.alu_op = AluInc;
            end
            OP_LD: begin
                strobes.a_we  = 1'b1;
                strobes.a_src = ASrcR;
            end
            OP_ST: begin
                strobes.r_we = 1'b1;
            end
            OP_NOP: begin
                strobes = STROBES_IDLE;
            end
            OP_LDI: begin
                strobes.a_we  = 1'b1;
                strobes.a_src = ASrcImm;
            end
            OP_RST: begin
                strobes.soft_rst = 1'b1;
            end
            default: begin
                strobes.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode sequencer.
// Cycles FETCH -> DECODE -> EXEC -> FETCH, one instruction per three cycles
// without stalls. Owns the PC, the instruction register and the strobe register.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   rom_addr    : program counter, drives the combinational ROM address
//   rom_data    : instruction word returned by the ROM
//   stall       : execute unit not ready; only honoured in EXEC
//   ir, imm     : instruction register and its immediate field IR[7:4]
//   exec_valid  : strobes are valid this cycle (EXEC)
//   a_we, a_src, alu_op, r_we, soft_rst, illegal : registered control strobes
module instr_fetch_decode
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]      rom_data,
    input  logic                  stall,
    output logic [WIDTH-1:0]      ir,
    output logic [3:0]            imm,
    output logic                  exec_valid,
    output logic                  a_we,
    output logic [1:0]            a_src,
    output logic [1:0]            alu_op,
    output logic                  r_we,
    output logic                  soft_rst,
    output logic                  illegal
);

    localparam logic [WIDTH-1:0] IR_RESET = {OP_NOP, {(WIDTH - 4){1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]      ir_q, ir_d;
    strobes_t              strb_q, strb_d;
    strobes_t              dec_strobes;
    logic                  commit;

    instr_decoder u_decoder (
        .opcode  (ir_q[WIDTH-1 -: 4]),
        .strobes (dec_strobes)
    );

    // Instruction retires on the first non-stalled EXEC cycle.
    assign commit = (state_q == StExec) && !stall;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: state_d = StExec;
            StExec:   state_d = commit ? StFetch : StExec;
            default:  state_d = StFetch;
        endcase
    end

    // FSM outputs
    always_comb begin
        exec_valid = (state_q == StExec);
        a_we       = strb_q.a_we;
        a_src      = strb_q.a_src;
        alu_op     = strb_q.alu_op;
        r_we       = strb_q.r_we;
        soft_rst   = strb_q.soft_rst;
        illegal    = strb_q.illegal;
        rom_addr   = pc_q;
        ir         = ir_q;
        imm        = ir_q[7:4];
    end

    // Datapath next state
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        strb_d = strb_q;
        case (state_q)
            StFetch: begin
                ir_d   = rom_data;
                strb_d = STROBES_IDLE;
            end
            StDecode: begin
                strb_d = dec_strobes;
            end
            StExec: begin
                if (commit) begin
                    // The adder wraps naturally; rst forces zero, which also covers PC = max.
                    pc_d   = strb_q.soft_rst ? '0 : pc_q + ADDR_WIDTH'(1);
                    strb_d = STROBES_IDLE;
                end
            end
            default: begin
                strb_d = STROBES_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            ir_q   <= IR_RESET;
            strb_q <= STROBES_IDLE;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            strb_q <= strb_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst;
    logic [3:0]  rom_addr;
    logic [11:0] rom_data;
    logic        stall;
    logic [11:0] ir;
    logic [3:0]  imm;
    logic        exec_valid;
    logic        a_we;
    logic [1:0]  a_src;
    logic [1:0]  alu_op;
    logic        r_we;
    logic        soft_rst;
    logic        illegal;

    logic [11:0] rom [16];
    logic [3:0]  pc_m;
    int          n_cmp;
    int          n_bad;

    assign rom_data = rom[rom_addr];

    instr_fetch_decode #(
        .WIDTH      (12),
        .ADDR_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .stall      (stall),
        .ir         (ir),
        .imm        (imm),
        .exec_valid (exec_valid),
        .a_we       (a_we),
        .a_src      (a_src),
        .alu_op     (alu_op),
        .r_we       (r_we),
        .soft_rst   (soft_rst),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {a_we, a_src[1:0], alu_op[1:0], r_we, soft_rst, illegal}
    function automatic logic [7:0] dut_vec();
        return {a_we, a_src, alu_op, r_we, soft_rst, illegal};
    endfunction

    // Opcode table: what the execute unit must see for each opcode.
    function automatic logic [7:0] expected_strobes(input logic [3:0] op);
        case (op)
            4'h5:    return {1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0};
            4'h9:    return {1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0};
            4'hA:    return {1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
            4'hB:    return {1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0};
            4'hC:    return 8'h00;
            4'hD:    return {1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0};
            4'hE:    return {1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
            default: return {1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_addr"}, 32'(rom_addr), 32'h0);
        chk({tag, "_ir"}, 32'(ir), 32'hC00);
        chk({tag, "_imm"}, 32'(imm), 32'h0);
        chk({tag, "_valid"}, 32'(exec_valid), 32'h0);
        chk({tag, "_strb"}, 32'(dut_vec()), 32'h0);
    endtask

    // Hold reset two cycles; leaves time at a negedge with reset released.
    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        chk_reset_values("reset_a");
        @(negedge clk);
        chk_reset_values("reset_b");
        rst  = 1'b0;
        pc_m = 4'h0;
        #1;
    endtask

    // One instruction from FETCH through commit; called at the FETCH negedge.
    task automatic run_instr(input int stalls);
        logic [11:0] word;
        logic [3:0]  op;
        word = rom[pc_m];
        op   = word[11:8];
        // FETCH: stall must be ignored here
        stall = 1'($urandom_range(0, 1));
        chk("fetch_addr", 32'(rom_addr), 32'(pc_m));
        chk("fetch_valid", 32'(exec_valid), 32'h0);
        chk("fetch_strb", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        // DECODE
        stall = 1'($urandom_range(0, 1));
        chk("decode_ir", 32'(ir), 32'(word));
        chk("decode_valid", 32'(exec_valid), 32'h0);
        chk("decode_strb", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        // EXEC, extended by one cycle per stall
        for (int k = 0; k <= stalls; k++) begin
            stall = (k < stalls);
            chk("exec_valid", 32'(exec_valid), 32'h1);
            chk("exec_strb", 32'(dut_vec()), 32'(expected_strobes(op)));
            chk("exec_imm", 32'(imm), 32'(word[7:4]));
            chk("exec_ir", 32'(ir), 32'(word));
            chk("exec_pc", 32'(rom_addr), 32'(pc_m));
            @(negedge clk);
        end
        stall = 1'b0;
        pc_m  = (op == 4'hE) ? 4'h0 : pc_m + 4'h1;
    endtask

    initial begin
        logic [3:0] ops [16];
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        stall = 1'b0;
        pc_m  = 4'h0;

        // Reference program
        rom[0]  = 12'hC00; rom[1]  = 12'hD20; rom[2]  = 12'hA00; rom[3]  = 12'h900;
        rom[4]  = 12'hB00; rom[5]  = 12'hC00; rom[6]  = 12'hD70; rom[7]  = 12'h500;
        rom[8]  = 12'h900; rom[9]  = 12'h300; rom[10] = 12'hB00; rom[11] = 12'h5F0;
        rom[12] = 12'hC00; rom[13] = 12'hD10; rom[14] = 12'hE00; rom[15] = 12'h900;

        do_reset();
        // Two passes through the program; the second stalls the inc at address 3.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 15; i++) begin
                run_instr((pass == 1 && pc_m == 4'h3) ? 3 : 0);
            end
            chk("rst_returns_to_0", 32'(rom_addr), 32'h0);
        end

        // Wrap: no rst instruction, PC rolls over from F to 0.
        rst = 1'b1;
        rom[14] = 12'hC00;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            run_instr(0);
        end

        // Randomized program with random stalls.
        ops = '{4'h5, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h0,
                4'h3, 4'h5, 4'h9, 4'hD, 4'hF, 4'h7, 4'hB, 4'hC};
        rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rom[a] = {ops[$urandom_range(0, 15)], 8'($urandom)};
        end
        do_reset();
        for (int i = 0; i < 40; i++) begin
            run_instr(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Reset asserted in the middle of DECODE aborts the instruction.
        rom[0] = 12'hD50; rom[1] = 12'h940; rom[2] = 12'hB00;
        rst = 1'b1;
        do_reset();
        run_instr(0);
        run_instr(0);
        chk("pre_abort_addr", 32'(rom_addr), 32'h2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_values("mid_decode");
        @(negedge clk);
        chk_reset_values("mid_decode_hold");
        rst  = 1'b0;
        pc_m = 4'h0;
        #1;
        run_instr(0);
        run_instr(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Instruction fetch and decode sequencer for the 12-bit microprocessor. It drives the address of the combinational 16-entry program ROM and captures the returned instruction word. It decodes the opcode and presents one-cycle registered control strobes to the execute unit (accumulator A, register R, ALU). It owns the program counter and handles sequential advance, wrap-around and the `rst` instruction.

## Interface
- `WIDTH`, 12: instruction word width.
- `ADDR_WIDTH`, 4: program counter and ROM address width.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `ROM_ADDR` output `ADDR_WIDTH`: program counter, wired directly to the ROM address.
- `ROM_DATA` input `WIDTH`: instruction word from the ROM, combinational in `ROM_ADDR`.
- `STALL` input 1: the execute unit is not ready, so hold in EXEC.
- `IR` output `WIDTH`: instruction register.
- `IMM` output 4: immediate, `IR[7:4]`.
- `EXEC_VALID` output 1: the strobes below are valid this cycle.
- `A_WE` output 1: write the accumulator.
- `A_SRC` output 2: accumulator source. 0 = ALU, 1 = R, 2 = IMM.
- `ALU_OP` output 2: 0 = none, 1 = ADD (A+R), 2 = INC (A+1).
- `R_WE` output 1: write R from A.
- `SOFT_RST` output 1: `rst` instruction; the execute unit clears A and R.
- `ILLEGAL` output 1: undefined opcode was executed.

## Operation
- State machine with three states: FETCH → DECODE → EXEC → FETCH.
  - FETCH: `ROM_ADDR` = PC. `IR` is loaded from `ROM_DATA` at the end of the cycle.
  - DECODE: the opcode in `IR[11:8]` is decoded into registered strobes, which are loaded at the end of the cycle.
  - EXEC: `EXEC_VALID` = 1 and the strobes are asserted. The instruction commits on the first EXEC cycle with `STALL` = 0. At that edge the PC updates and the state returns to FETCH.
- Opcode map (`IR[11:8]`):
  - 5 add: `A_WE`, `A_SRC`=0, `ALU_OP`=ADD.
  - 9 inc: `A_WE`, `A_SRC`=0, `ALU_OP`=INC.
  - A ld: `A_WE`, `A_SRC`=1.
  - B st: `R_WE`.
  - C nop: no strobes.
  - D ldi: `A_WE`, `A_SRC`=2.
  - E rst: `SOFT_RST`.
  - Any other opcode: no strobes except `ILLEGAL`; the instruction otherwise behaves as nop.
- `IR[3:0]` is reserved and ignored.
- PC update on commit:
  - `rst`: PC ← 0.
  - Otherwise PC ← PC+1, modulo 2^`ADDR_WIDTH`, so 4'hF wraps to 4'h0.
- Strobes are 0 in FETCH and DECODE. They are held constant through EXEC for the whole duration of any stall.
- `STALL` is ignored outside EXEC.

## Timing
- Reset values, applied asynchronously and held while `RST` = 1:
  - state = FETCH, PC = 0, `IR` = 12'hC00 (nop), `IMM` = 0.
  - All strobes, `EXEC_VALID` and `ILLEGAL` = 0.
- Sequencing with no stalls:
  - Instruction n: FETCH at cycle 3n, EXEC at cycle 3n+2.
  - Issue rate is one instruction per 3 cycles.
- Latency: 2 cycles from `ROM_ADDR` presentation to the strobes.
- Each stall cycle extends EXEC by one cycle. PC and `IR` are frozen for the duration.
- `RST` asserted in any state aborts the instruction in flight; no commit happens. After deassertion, the first rising edge begins FETCH of address 0.
- `rst` at PC = 4'hF: PC goes to 0. The wrap and `rst` give the same result; no conflict.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants: `OP_ADD`=4'h5, `OP_INC`=4'h9, `OP_LD`=4'hA, `OP_ST`=4'hB, `OP_NOP`=4'hC, `OP_LDI`=4'hD, `OP_RST`=4'hE.
  - `A_SRC` and `ALU_OP` encodings.
  - FSM state encodings.
- One sub-module, `instr_decoder`: combinational, opcode → strobe vector. It is registered in this block during DECODE.
- This block contains the PC, `IR`, FSM and the strobe register.

## Test plan
- Reset: hold `RST` for 2 cycles, then release.
  - → `ROM_ADDR`=0, `IR`=12'hC00, all strobes 0.
  - First EXEC (cycle 2) shows nop with `ILLEGAL`=0.
- Reference program, address 1 = 12'hD20 (ldi).
  - → cycle 5: `EXEC_VALID`=1, `A_WE`=1, `A_SRC`=2, `IMM`=4'h2.
  - → cycle 6: `ROM_ADDR`=2.
- Address 7 = 12'h500 (add) → cycle 23: `A_WE`=1, `ALU_OP`=ADD. Address 4 = 12'hB00 (st) → cycle 14: `R_WE`=1 only.
- `rst` at address E.
  - → cycle 44: `SOFT_RST`=1.
  - → cycle 45: `ROM_ADDR`=0.
  - Program repeats identically.
- Wrap: replace address E with 12'hC00.
  - → after the EXEC of address F, `ROM_ADDR`=0.
  - No `SOFT_RST` pulse.
- Stall and illegal opcodes:
  - Raise `STALL` for 3 cycles during EXEC of 12'h900 → `A_WE` and `ALU_OP`=INC are held for 4 cycles; PC advances once.
  - Opcode 4'h3 → `ILLEGAL`=1 for one EXEC; all other strobes 0.
  - Assert `RST` mid-DECODE → immediate return to the reset values.
